tlb_test_controller: RTL and testbench

Sequencer behind the test register file that executes Intel386 TLB test commands. A write to TR6 launches a TLB write (C=0) or a TLB lookup (C=1) against the paging TLB array port. A lookup result is written back into TR7 through the register file's write port. It sits between the register-file write bus and the TLB array, and its `busy` output gates further test-register writes.

---
 rtl/tlb_test_pkg.sv | 79 +++++++
 rtl/tlb_test_match.sv | 30 +++
 rtl/tlb_test_controller.sv | 174 +++++++++++++++++
 tb/tb_tlb_test_controller.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_test_pkg.sv
// tlb_test_pkg: shared types for the i386 TLB test-register sequencer.
//   - FSM state enum
//   - TR6 / TR7 packed layouts and their field bit positions
//   - TLB entry header (the flag/pfn bits that sit above the tag)
//   - helpers: attribute-pair compare, TR7 hit word builder
package tlb_test_pkg;

  localparam int SETS_DEF = 8;
  localparam int WAYS_DEF = 4;

  localparam logic [2:0] TR6_INDEX = 3'd6;

  // TR6 field positions
  localparam int TR6_LIN_LSB = 12;
  localparam int TR6_V_BIT   = 11;
  localparam int TR6_D_BIT   = 10;
  localparam int TR6_DN_BIT  = 9;
  localparam int TR6_U_BIT   = 8;
  localparam int TR6_UN_BIT  = 7;
  localparam int TR6_W_BIT   = 6;
  localparam int TR6_WN_BIT  = 5;
  localparam int TR6_C_BIT   = 0;

  // TR7 field positions
  localparam int TR7_PFN_LSB = 12;
  localparam int TR7_PL_BIT  = 4;
  localparam int TR7_REP_LSB = 2;
  localparam int TR7_HT_BIT  = 1;

  // Entry = {hdr, tag}; the header width is fixed, the tag width follows SETS.
  localparam int ENT_HDR_W = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DONE} state_e;

  typedef struct packed {
    logic [19:0] linear;
    logic        v;
    logic        d;
    logic        dn;
    logic        u;
    logic        un;
    logic        w;
    logic        wn;
    logic [3:0]  rsvd;
    logic        c;
  } tr6_t;

  typedef struct packed {
    logic [19:0] pfn;
    logic [6:0]  rsvd1;
    logic        pl;
    logic [1:0]  rep;
    logic        ht;
    logic        rsvd0;
  } tr7_t;

  typedef struct packed {
    logic        v;
    logic        d;
    logic        u;
    logic        w;
    logic [19:0] pfn;
  } tlb_entry_t;

  // A pair with X == X# is don't-care; otherwise the entry bit must equal X.
  function automatic logic attr_ok(input logic x, input logic xn, input logic e);
    return (x == xn) || (e == x);
  endfunction

  function automatic logic [31:0] tr7_hit_word(input logic [19:0] pfn, input logic [1:0] way);
    tr7_t r;
    r     = '0;
    r.pfn = pfn;
    r.rep = way;
    r.ht  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/tlb_test_match.sv
// tlb_test_match: combinational hit compare of one TLB entry against a TR6
// command. Also usable by the paging unit's own lookup path.
//   entry : {V, D, U, W, pfn[19:0], tag}
//   cmd   : latched TR6 (D/D#, U/U#, W/W# pairs)
//   tag   : expected tag (linear[31:12+log2(SETS)])
//   hit   : valid && tag match && all cared-for attributes match
module tlb_test_match
  import tlb_test_pkg::*;
#(
  parameter int TAG_W = 17
) (
  input  logic [TAG_W+ENT_HDR_W-1:0] entry,
  input  tr6_t                       cmd,
  input  logic [TAG_W-1:0]           tag,
  output logic                       hit
);

  tlb_entry_t hdr;
  logic       unused_ok;

  assign hdr = entry[TAG_W +: ENT_HDR_W];

  assign hit = hdr.v && (entry[TAG_W-1:0] == tag) &&
               attr_ok(cmd.d, cmd.dn, hdr.d) &&
               attr_ok(cmd.u, cmd.un, hdr.u) &&
               attr_ok(cmd.w, cmd.wn, hdr.w);

  assign unused_ok = ^{hdr.pfn, cmd.linear, cmd.v, cmd.rsvd, cmd.c};

endmodule

// File: rtl/tlb_test_controller.sv
// tlb_test_controller: executes TR6-triggered TLB write / lookup commands.
//   clock, reset (sync, active-low)
//   tr_write_*        : snooped register-file write bus (TR6 = index 6)
//   TR7               : current TR7 value, latched with the command
//   busy              : state != IDLE (gates further test-register writes)
//   tlb_req/we/set/way/wdata, tlb_ack/rdata : TLB array port
//   tr7_write_enable/data : lookup result write-back
//   done              : one-cycle completion pulse
// All outputs come straight from flops computed from the next state.
module tlb_test_controller
  import tlb_test_pkg::*;
#(
  parameter int SETS  = SETS_DEF,
  parameter int WAYS  = WAYS_DEF,
  parameter int TAG_W = 20 - $clog2(SETS)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tr_write_enable,
  input  logic [2:0]                 tr_write_index,
  input  logic [31:0]                tr_write_data,
  input  logic [31:0]                TR7,
  output logic                       busy,
  output logic                       tlb_req,
  output logic                       tlb_we,
  output logic [$clog2(SETS)-1:0]    tlb_set,
  output logic [$clog2(WAYS)-1:0]    tlb_way,
  output logic [TAG_W+ENT_HDR_W-1:0] tlb_wdata,
  input  logic                       tlb_ack,
  input  logic [TAG_W+ENT_HDR_W-1:0] tlb_rdata,
  output logic                       tr7_write_enable,
  output logic [31:0]                tr7_write_data,
  output logic                       done
);

  localparam int SB = $clog2(SETS);
  localparam int WB = $clog2(WAYS);
  localparam int EW = TAG_W + ENT_HDR_W;

  state_e         state_q, state_d;
  tr6_t           cmd_q, cmd_d;
  tr7_t           tr7_q, tr7_d;
  logic [WB-1:0]  rr_q, rr_d;
  logic [WB-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [SB-1:0]  set_q, set_d;
  logic [WB-1:0]  way_q, way_d;
  logic [EW-1:0]  wdata_q, wdata_d;
  logic           done_q, done_d;
  logic           tr7_we_q, tr7_we_d;
  logic [31:0]    tr7_wdata_q, tr7_wdata_d;
  logic           hit;
  tlb_entry_t     rd_hdr;
  logic           unused_ok;

  assign rd_hdr = tlb_rdata[TAG_W +: ENT_HDR_W];

  tlb_test_match #(.TAG_W(TAG_W)) u_match (
    .entry (tlb_rdata),
    .cmd   (cmd_q),
    .tag   (cmd_q.linear[19:SB]),
    .hit   (hit)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    tr7_d       = tr7_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    tr7_we_d    = 1'b0;
    tr7_wdata_d = '0;

    // tlb_req is always high in WRITE/READ, so tlb_ack alone qualifies a handshake.
    unique case (state_q)
      ST_IDLE: begin
        if (tr_write_enable && tr_write_index == TR6_INDEX) begin
          cmd_d   = tr6_t'(tr_write_data);
          tr7_d   = tr7_t'(TR7);
          cnt_d   = '0;
          state_d = cmd_d.c ? ST_READ : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (tlb_ack) begin
          if (!tr7_q.pl) rr_d = rr_q + WB'(1);
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_READ: begin
        if (tlb_ack) begin
          if (hit) begin
            state_d     = ST_DONE;
            done_d      = 1'b1;
            tr7_we_d    = 1'b1;
            tr7_wdata_d = tr7_hit_word(rd_hdr.pfn, 2'(cnt_q));
          end else if (cnt_q == WB'(WAYS-1)) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            tr7_we_d = 1'b1;
          end else begin
            cnt_d = cnt_q + WB'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    req_d   = (state_d == ST_WRITE) || (state_d == ST_READ);
    we_d    = (state_d == ST_WRITE);
    set_d   = '0;
    way_d   = '0;
    wdata_d = '0;
    if (req_d) begin
      set_d   = cmd_d.linear[SB-1:0];
      way_d   = we_d ? (tr7_d.pl ? WB'(tr7_d.rep) : rr_d) : cnt_d;
      wdata_d = we_d ? {cmd_d.v, cmd_d.d, cmd_d.u, cmd_d.w, tr7_d.pfn, cmd_d.linear[19:SB]} : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      tr7_q       <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      set_q       <= '0;
      way_q       <= '0;
      wdata_q     <= '0;
      done_q      <= 1'b0;
      tr7_we_q    <= 1'b0;
      tr7_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      tr7_q       <= tr7_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      we_q        <= we_d;
      set_q       <= set_d;
      way_q       <= way_d;
      wdata_q     <= wdata_d;
      done_q      <= done_d;
      tr7_we_q    <= tr7_we_d;
      tr7_wdata_q <= tr7_wdata_d;
    end
  end

  assign busy             = busy_q;
  assign tlb_req          = req_q;
  assign tlb_we           = we_q;
  assign tlb_set          = set_q;
  assign tlb_way          = way_q;
  assign tlb_wdata        = wdata_q;
  assign done             = done_q;
  assign tr7_write_enable = tr7_we_q;
  assign tr7_write_data   = tr7_wdata_q;

  assign unused_ok = ^{cmd_q.rsvd, tr7_q.rsvd1, tr7_q.ht, tr7_q.rsvd0, rd_hdr.v, rd_hdr.d,
                       rd_hdr.u, rd_hdr.w};

endmodule

// File: tb/tb_tlb_test_controller.sv
module tb_tlb_test_controller;

  logic        clock, reset;
  logic        tr_write_enable;
  logic [2:0]  tr_write_index;
  logic [31:0] tr_write_data, tr7_in;
  logic        busy, tlb_req, tlb_we, tlb_ack, tr7_write_enable, done;
  logic [2:0]  tlb_set;
  logic [1:0]  tlb_way;
  logic [40:0] tlb_wdata, tlb_rdata;
  logic [31:0] tr7_write_data;

  int checks = 0;
  int errors = 0;

  // per-command observations from run_cmd
  logic [40:0] mem [8][4];
  int          n_req, n_tr7, done_cyc;
  logic [31:0] tr7_last;
  logic [2:0]  rq_set   [8];
  logic [1:0]  rq_way   [8];
  logic        rq_we    [8];
  logic [40:0] rq_wdata [8];

  tlb_test_controller dut (
    .clock(clock), .reset(reset),
    .tr_write_enable(tr_write_enable), .tr_write_index(tr_write_index),
    .tr_write_data(tr_write_data), .TR7(tr7_in),
    .busy(busy), .tlb_req(tlb_req), .tlb_we(tlb_we), .tlb_set(tlb_set),
    .tlb_way(tlb_way), .tlb_wdata(tlb_wdata), .tlb_ack(tlb_ack), .tlb_rdata(tlb_rdata),
    .tr7_write_enable(tr7_write_enable), .tr7_write_data(tr7_write_data), .done(done)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic logic [40:0] mk_entry(input bit v, d, u, w, input logic [19:0] pfn,
                                           input logic [16:0] tag);
    return {v, d, u, w, pfn, tag};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge clock); @(negedge clock); end
  endtask

  // Issue a TR6 write at the current negedge, act as the TLB array with `delay`
  // wait cycles per access, and record what the DUT does. Cycle 1 is the first
  // cycle after the trigger edge. Optionally inject a TR6 write during cycle
  // inj_cyc and/or in the DONE cycle (then return one cycle after DONE).
  task automatic run_cmd(input logic [31:0] tr6, input logic [31:0] tr7v, input int delay,
                         input int inj_cyc, input bit inj_done, input logic [31:0] inj_tr6);
    int wcnt;
    bit fin;
    n_req = 0; n_tr7 = 0; tr7_last = '0; done_cyc = -1; wcnt = 0; fin = 0;
    tr_write_enable = 1; tr_write_index = 3'd6; tr_write_data = tr6; tr7_in = tr7v;
    @(posedge clock); @(negedge clock);
    tr_write_enable = 0;
    for (int c = 1; c <= 40 && !fin; c++) begin
      tlb_ack = 0;
      if (tr7_write_enable) begin n_tr7++; tr7_last = tr7_write_data; end
      if (done) begin
        done_cyc = c; fin = 1;
        if (inj_done) begin
          tr_write_enable = 1; tr_write_data = inj_tr6;
          @(posedge clock); @(negedge clock);
          tr_write_enable = 0;
        end
      end else begin
        if (tlb_req) begin
          if (wcnt == delay) begin
            tlb_ack = 1; tlb_rdata = mem[tlb_set][tlb_way]; wcnt = 0;
            if (n_req < 8) begin
              rq_set[n_req] = tlb_set; rq_way[n_req] = tlb_way;
              rq_we[n_req] = tlb_we; rq_wdata[n_req] = tlb_wdata;
            end
            n_req++;
            if (tlb_we) mem[tlb_set][tlb_way] = tlb_wdata;
          end else wcnt++;
        end
        tr_write_enable = (c == inj_cyc);
        if (c == inj_cyc) tr_write_data = inj_tr6;
        @(posedge clock); @(negedge clock);
      end
    end
    tlb_ack = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    idle(3);
    checks++;
    if ({busy, tlb_req, tlb_we, done, tr7_write_enable} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {busy, tlb_req, tlb_we, done, tr7_write_enable});
    end
    checks++;
    if ({tlb_set, tlb_way, tlb_wdata, tr7_write_data} !== '0) begin
      errors++; $display("FAIL reset_data got %0h want 0", {tlb_set, tlb_way, tlb_wdata, tr7_write_data});
    end
    reset = 1;
    idle(1);
  endtask

  // TR7 = pfn 0x12345, PL=1, REP=3. TR6 = linear 0x00403, 0xA40 -> V=1, D=0, U=0, W=1.
  task automatic test_write_pl1;
    run_cmd(32'h00403A40, 32'h1234501C, 0, 0, 0, 0);
    checks++; if (n_req !== 1) begin errors++; $display("FAIL wr_nreq got %0d want 1", n_req); end
    checks++; if (rq_set[0] !== 3'd3) begin errors++; $display("FAIL wr_set got %0d want 3", rq_set[0]); end
    checks++; if (rq_way[0] !== 2'd3) begin errors++; $display("FAIL wr_way got %0d want 3", rq_way[0]); end
    checks++; if (rq_we[0] !== 1'b1) begin errors++; $display("FAIL wr_we got %b want 1", rq_we[0]); end
    checks++;
    if (rq_wdata[0] !== {4'b1001, 20'h12345, 17'h00080}) begin
      errors++; $display("FAIL wr_wdata got %0h want %0h", rq_wdata[0], {4'b1001, 20'h12345, 17'h00080});
    end
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL wr_done got %0d want 2", done_cyc); end
    checks++; if (n_tr7 !== 0) begin errors++; $display("FAIL wr_tr7 got %0d want 0", n_tr7); end
    idle(1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_idle busy got %b want 0", busy); end
  endtask

  // linear 0x12345 -> set 5, tag 0x2468. way0 tag mismatch, way1 invalid, way2 hits.
  task automatic test_lookup_hit;
    mem[5][0] = mk_entry(1, 0, 0, 0, 20'h11111, 17'h2469);
    mem[5][1] = mk_entry(0, 0, 0, 0, 20'h22222, 17'h2468);
    mem[5][2] = mk_entry(1, 1, 1, 1, 20'h12345, 17'h2468);
    idle(1);
    run_cmd(32'h12345801, 32'h0, 1, 0, 0, 0);
    checks++; if (n_req !== 3) begin errors++; $display("FAIL lk_nreq got %0d want 3", n_req); end
    checks++;
    if ({rq_way[0], rq_way[1], rq_way[2]} !== 6'b00_01_10) begin
      errors++; $display("FAIL lk_ways got %b want 000110", {rq_way[0], rq_way[1], rq_way[2]});
    end
    checks++;
    if ({rq_we[0], rq_we[1], rq_we[2], rq_set[2]} !== {3'b000, 3'd5}) begin
      errors++; $display("FAIL lk_we_set got %b want 000101", {rq_we[0], rq_we[1], rq_we[2], rq_set[2]});
    end
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL lk_done got %0d want 7", done_cyc); end
    checks++; if (n_tr7 !== 1) begin errors++; $display("FAIL lk_ntr7 got %0d want 1", n_tr7); end
    checks++;
    if (tr7_last !== 32'h1234500A) begin
      errors++; $display("FAIL lk_tr7 got %0h want 1234500a", tr7_last);
    end
  endtask

  // linear 0x00011 -> set 1, tag 2. Entry way0: V=1, D=0.
  task automatic test_dont_care;
    mem[1][0] = mk_entry(1, 0, 1, 1, 20'hABCDE, 17'h2);
    idle(1);
    run_cmd(32'h00011E01, 32'h0, 0, 0, 0, 0);  // D=D#=1: don't-care
    checks++; if (done_cyc !== 2) begin errors++; $display("FAIL dc_done got %0d want 2", done_cyc); end
    checks++;
    if (tr7_last !== 32'hABCDE002) begin
      errors++; $display("FAIL dc_tr7 got %0h want abcde002", tr7_last);
    end
    idle(1);
    run_cmd(32'h00011C01, 32'h0, 0, 0, 0, 0);  // D=1, D#=0: entry D=0 misses
    checks++; if (n_req !== 4) begin errors++; $display("FAIL miss_nreq got %0d want 4", n_req); end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL miss_done got %0d want 5", done_cyc); end
    checks++;
    if (n_tr7 !== 1 || tr7_last !== 32'h0) begin
      errors++; $display("FAIL miss_tr7 got n=%0d d=%0h want n=1 d=0", n_tr7, tr7_last);
    end
  endtask

  task automatic test_round_robin;
    int exp_way [6] = '{0, 1, 3, 2, 3, 0};
    bit pl      [6] = '{0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      idle(1);
      run_cmd(32'h00006800, pl[i] ? 32'h0000A01C : 32'h0000A000, 0, 0, 0, 0);
      checks++;
      if (n_req !== 1 || rq_way[0] !== 2'(exp_way[i]) || rq_set[0] !== 3'd6) begin
        errors++;
        $display("FAIL rr_%0d got n=%0d way=%0d set=%0d want n=1 way=%0d set=6", i, n_req,
                 rq_way[0], rq_set[0], exp_way[i]);
      end
    end
  endtask

  // Miss lookup on set 0 with a TR6 write injected in READ and in DONE.
  task automatic test_busy_ignore;
    idle(1);
    run_cmd(32'h00008801, 32'h0, 1, 3, 1, 32'h00007800);
    checks++; if (n_req !== 4) begin errors++; $display("FAIL ign_nreq got %0d want 4", n_req); end
    checks++;
    if ({rq_we[0], rq_we[1], rq_we[2], rq_we[3]} !== 4'b0) begin
      errors++; $display("FAIL ign_we got %b want 0000", {rq_we[0], rq_we[1], rq_we[2], rq_we[3]});
    end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL ign_done got %0d want 9", done_cyc); end
    checks++;
    if ({busy, tlb_req} !== 2'b00) begin
      errors++; $display("FAIL ign_after got busy=%b req=%b want 0 0", busy, tlb_req);
    end
    // one cycle after DONE: accepted; pointer was 1 after the round-robin run
    run_cmd(32'h00007800, 32'h0, 0, 0, 0, 0);
    checks++;
    if (n_req !== 1 || rq_set[0] !== 3'd7 || rq_way[0] !== 2'd1 || done_cyc !== 2) begin
      errors++;
      $display("FAIL acc_after got n=%0d set=%0d way=%0d done=%0d want 1 7 1 2", n_req,
               rq_set[0], rq_way[0], done_cyc);
    end
  endtask

  task automatic test_reset_abort;
    bit seen;
    idle(1);
    tlb_ack = 0;
    tr_write_enable = 1; tr_write_index = 3'd6; tr_write_data = 32'h00006800; tr7_in = 32'h0;
    @(posedge clock); @(negedge clock);
    tr_write_enable = 0;
    idle(2);
    checks++; if (tlb_req !== 1'b1) begin errors++; $display("FAIL ab_wait req got %b want 1", tlb_req); end
    reset = 0;
    @(posedge clock); @(negedge clock);
    checks++;
    if ({tlb_req, busy, done, tr7_write_enable} !== 4'b0) begin
      errors++; $display("FAIL ab_reset got %b want 0000", {tlb_req, busy, done, tr7_write_enable});
    end
    reset = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (done || tr7_write_enable || tlb_req) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL ab_quiet got activity want none"); end
    run_cmd(32'h00006800, 32'h0, 0, 0, 0, 0);
    checks++;
    if (n_req !== 1 || rq_way[0] !== 2'd0 || done_cyc !== 2) begin
      errors++; $display("FAIL ab_ptr got n=%0d way=%0d done=%0d want 1 0 2", n_req, rq_way[0], done_cyc);
    end
  endtask

  initial begin
    reset = 0; tr_write_enable = 0; tr_write_index = 0; tr_write_data = 0; tr7_in = 0;
    tlb_ack = 0; tlb_rdata = 0;
    for (int s = 0; s < 8; s++) for (int w = 0; w < 4; w++) mem[s][w] = '0;
    @(negedge clock);
    test_reset;
    test_write_pl1;
    test_lookup_hit;
    test_dont_care;
    test_round_robin;
    test_busy_ignore;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
